shared_out_arbiter: RTL
=======================

SHARED_OUT_ARBITER -- requirements
Module: shared_out_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of payload on every data port.
REQ-002 Parameter: CNT_W, 16, width of transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous to clk and active-high.
REQ-005 in0_data  input  DATA_W  requester 0 payload.
REQ-006 in0_sync  input  1  requester 0 has valid payload.
REQ-007 in0_notify  output  1  arbiter accepts requester 0 payload this cycle.
REQ-008 in1_data, in1_sync, in1_notify  same as REQ-005..007 for requester 1.
REQ-009 out_data  output  DATA_W  payload offered downstream.
REQ-010 out_sync  input  1  downstream ready to take out_data.
REQ-011 out_notify  output  1  out_data is valid and pending.
REQ-012 xfer_count  output  CNT_W  completed downstream transfers.
REQ-013 last_grant  output  1  index of most recently accepted requester.

Function
REQ-014 Block SHALL be a two-state machine, sections IDLE and SEND.
REQ-015 Transfer on the output side SHALL occur in a cycle where out_notify and out_sync are both high.
REQ-016 In IDLE with exactly one inX_sync high, the block SHALL assert inX_notify combinationally in that cycle, capture inX_data into out_data at the clock edge, set last_grant to X, enter SEND.
REQ-017 In IDLE with both syncs high, the grant SHALL go to the requester not equal to last_grant (round-robin); the other notify SHALL stay low.
REQ-018 In IDLE with no sync high, the block SHALL remain in IDLE and keep both notifies low.
REQ-019 inX_notify SHALL be low in SEND and never high for both requesters in the same cycle.
REQ-020 In SEND, out_notify SHALL be high and out_data SHALL be stable until transfer.
REQ-021 On transfer, the block SHALL return to IDLE next cycle, drop out_notify, and increment xfer_count by 1.
REQ-022 xfer_count SHALL wrap from 2^CNT_W-1 to 0 without saturation.
REQ-023 Latency: payload accepted in cycle N SHALL be offered (out_notify high) from cycle N+1; peak throughput one transfer per two cycles.
REQ-024 Requester sync changes during SEND SHALL have no effect on state or outputs.
REQ-025 out_data SHALL hold its last value while in IDLE.

Reset
REQ-026 With rst high at a clock edge: section IDLE, out_data 0, out_notify 0, xfer_count 0, last_grant 1, regardless of current state.
REQ-027 in0_notify and in1_notify SHALL be low in any cycle rst is high.
REQ-028 A payload pending in SEND when rst asserts SHALL be discarded and not counted.
REQ-029 First grant after reset with both syncs high SHALL go to requester 0.

Structure
REQ-030 Package shared_out_arbiter_types SHALL hold the section enum (IDLE, SEND) and default DATA_W/CNT_W constants.
REQ-031 Round-robin selection SHALL be inline; no sub-module is required.

Verification
REQ-032 Reset, then in0_sync=1, in0_data=0x11, out_sync=1 -> in0_notify high cycle 1, out_notify/out_data=0x11 cycle 2, xfer_count=1 cycle 3.
REQ-033 Both syncs held high, data 0xA0/0xB0, out_sync=1 -> accepted order 0xA0,0xB0,0xA0,0xB0; last_grant toggles 0,1,0,1.
REQ-034 Accept 0x22, hold out_sync=0 for 5 cycles with in1_sync toggling -> out_data stays 0x22, both notifies low, count unchanged until out_sync=1.
REQ-035 Preload 65535 transfers (CNT_W=16), one more -> xfer_count wraps to 0.
REQ-036 rst high while in SEND with 0x33 pending -> next cycle IDLE, out_notify 0, out_data 0, xfer_count 0, no transfer of 0x33.

Source files
------------

// File: rtl/shared_out_arbiter_pkg.sv
// Shared types for the two-requester output arbiter: section encoding and
// default widths.
package shared_out_arbiter_types;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } section_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/shared_out_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output slot.
// Accepts one payload in IDLE, then holds it in SEND until downstream takes it.
module shared_out_arbiter
  import shared_out_arbiter_types::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_sync,
  output logic              in0_notify,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_sync,
  output logic              in1_notify,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_sync,
  output logic              out_notify,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              last_grant
);

  section_t section;

  // Grant is combinational so the requester sees acceptance in the same cycle;
  // on contention the requester that did not win last time goes first.
  always_comb begin
    in0_notify = 1'b0;
    in1_notify = 1'b0;
    if (!rst && section == IDLE) begin
      if (in0_sync && in1_sync) begin
        in0_notify = last_grant;
        in1_notify = !last_grant;
      end else if (in0_sync) begin
        in0_notify = 1'b1;
      end else if (in1_sync) begin
        in1_notify = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      section    <= IDLE;
      out_data   <= '0;
      out_notify <= 1'b0;
      xfer_count <= '0;
      last_grant <= 1'b1;
    end else begin
      case (section)
        IDLE: begin
          if (in0_notify) begin
            out_data   <= in0_data;
            last_grant <= 1'b0;
            out_notify <= 1'b1;
            section    <= SEND;
          end else if (in1_notify) begin
            out_data   <= in1_data;
            last_grant <= 1'b1;
            out_notify <= 1'b1;
            section    <= SEND;
          end
        end
        SEND: begin
          if (out_sync) begin
            out_notify <= 1'b0;
            xfer_count <= xfer_count + CNT_W'(1);
            section    <= IDLE;
          end
        end
        default: begin
          section    <= IDLE;
          out_notify <= 1'b0;
        end
      endcase
    end
  end

endmodule
